// File: rtl/adder_entry_ctrl.sv
// Operand-entry and compute sequencer for the 4-bit adder lab: debounced keys, A/B capture,
// result latch and digit selection. Optional carry blink enabled by defining CARRY_BLINK_EN.
module adder_entry_ctrl #(
    parameter logic [19:0] DEB_CYCLES   = 20'd500000,
    parameter logic [24:0] BLINK_CYCLES = 25'd12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       key_a_n,
    input  logic       key_b_n,
    input  logic       key_cal_n,
    input  logic [3:0] sum,
    input  logic       cout,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic [3:0] disp0,
    output logic [3:0] disp1,
    output logic       disp_blank,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        READY   = 2'd2,
        RESULT  = 2'd3
    } state_t;

    // Key index 0 = A, 1 = B, 2 = CAL
    logic [2:0]  keys_s;
    logic [2:0]  sync1_r;
    logic [2:0]  sync2_r;
    logic [2:0]  level_r;
    logic [2:0]  ignore_r;
    logic [2:0]  press_r;
    logic [19:0] cnt_r [3];

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  op_a_r, op_a_nxt_s;
    logic [3:0]  op_b_r, op_b_nxt_s;
    logic [3:0]  res_sum_r, res_sum_nxt_s;
    logic        res_c_r, res_c_nxt_s;
    logic [3:0]  disp0_r;
    logic [3:0]  disp1_r;
    logic        ev_a_s;
    logic        ev_b_s;
    logic        ev_cal_s;

    assign keys_s = {key_cal_n, key_b_n, key_a_n};

    // Synchronize and debounce each key; ignore_r masks a key held through reset until a
    // debounced release has been seen, so it cannot produce a spurious press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= 3'b111;
            sync2_r  <= 3'b111;
            level_r  <= 3'b111;
            ignore_r <= 3'b111;
            press_r  <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                cnt_r[k] <= 20'd0;
            end
        end else begin
            sync1_r <= keys_s;
            sync2_r <= sync1_r;
            press_r <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                if (ignore_r[k]) begin
                    if (sync2_r[k]) begin
                        if (cnt_r[k] == DEB_CYCLES - 20'd1) begin
                            cnt_r[k]    <= 20'd0;
                            ignore_r[k] <= 1'b0;
                        end else begin
                            cnt_r[k] <= cnt_r[k] + 20'd1;
                        end
                    end else begin
                        cnt_r[k] <= 20'd0;
                    end
                end else if (sync2_r[k] != level_r[k]) begin
                    if (cnt_r[k] == DEB_CYCLES - 20'd1) begin
                        cnt_r[k]   <= 20'd0;
                        level_r[k] <= sync2_r[k];
                        press_r[k] <= ~sync2_r[k];
                    end else begin
                        cnt_r[k] <= cnt_r[k] + 20'd1;
                    end
                end else begin
                    cnt_r[k] <= 20'd0;
                end
            end
        end
    end

    assign ev_cal_s = press_r[2];
    assign ev_a_s   = press_r[0] & ~press_r[2];
    assign ev_b_s   = press_r[1] & ~press_r[2] & ~press_r[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ENTER_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ENTER_A: begin
                if (ev_a_s) state_nxt_s = ENTER_B;
                else        state_nxt_s = ENTER_A;
            end
            ENTER_B: begin
                if (ev_b_s) state_nxt_s = READY;
                else        state_nxt_s = ENTER_B;
            end
            READY: begin
                if (ev_cal_s) state_nxt_s = RESULT;
                else          state_nxt_s = READY;
            end
            RESULT: begin
                if (ev_cal_s) state_nxt_s = ENTER_A;
                else          state_nxt_s = RESULT;
            end
            default: state_nxt_s = ENTER_A;
        endcase
    end

    // Next values of operand and result registers
    always_comb begin
        op_a_nxt_s    = op_a_r;
        op_b_nxt_s    = op_b_r;
        res_sum_nxt_s = res_sum_r;
        res_c_nxt_s   = res_c_r;
        case (state_r)
            ENTER_A, ENTER_B, READY: begin
                if (ev_cal_s && state_r == READY) begin
                    res_sum_nxt_s = sum;
                    res_c_nxt_s   = cout;
                end else if (ev_a_s) begin
                    op_a_nxt_s = sw;
                end else if (ev_b_s) begin
                    op_b_nxt_s = sw;
                end else begin
                    op_a_nxt_s = op_a_r;
                end
            end
            RESULT: begin
                if (ev_cal_s) begin
                    op_a_nxt_s    = 4'd0;
                    op_b_nxt_s    = 4'd0;
                    res_sum_nxt_s = 4'd0;
                    res_c_nxt_s   = 1'b0;
                end else begin
                    op_a_nxt_s = op_a_r;
                end
            end
            default: begin
                op_a_nxt_s = 4'd0;
                op_b_nxt_s = 4'd0;
            end
        endcase
    end

    // Operand and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r    <= 4'd0;
            op_b_r    <= 4'd0;
            res_sum_r <= 4'd0;
            res_c_r   <= 1'b0;
        end else begin
            op_a_r    <= op_a_nxt_s;
            op_b_r    <= op_b_nxt_s;
            res_sum_r <= res_sum_nxt_s;
            res_c_r   <= res_c_nxt_s;
        end
    end

    // Digit selection, one cycle behind state and registers
    always_ff @(posedge clk) begin
        if (rst) begin
            disp0_r <= 4'd0;
            disp1_r <= 4'd0;
        end else begin
            case (state_r)
                RESULT: begin
                    disp0_r <= res_sum_r;
                    disp1_r <= {3'b000, res_c_r};
                end
                default: begin
                    disp0_r <= op_a_r;
                    disp1_r <= op_b_r;
                end
            endcase
        end
    end

`ifdef CARRY_BLINK_EN
    logic [24:0] blink_cnt_r;
    logic        blink_r;

    // Carry blink: toggles only while a carry result is displayed
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_r <= 25'd0;
            blink_r     <= 1'b0;
        end else if (state_r == RESULT && res_c_r) begin
            if (blink_cnt_r == BLINK_CYCLES - 25'd1) begin
                blink_cnt_r <= 25'd0;
                blink_r     <= ~blink_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + 25'd1;
            end
        end else begin
            blink_cnt_r <= 25'd0;
            blink_r     <= 1'b0;
        end
    end

    assign disp_blank = blink_r;
`else
    logic unused_blink_s;
    assign unused_blink_s = ^BLINK_CYCLES;
    assign disp_blank     = 1'b0;
`endif

    assign op_a  = op_a_r;
    assign op_b  = op_b_r;
    assign disp0 = disp0_r;
    assign disp1 = disp1_r;
    assign state = state_r;

endmodule

// File: tb/tb_adder_entry_ctrl.sv
// Scoreboard bench for adder_entry_ctrl: directed key sequences push expected snapshots,
// a monitor compares whenever state/op_a/op_b change.
module tb_adder_entry_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d0;
        logic [3:0] d1;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = 4'd0;
    logic       key_a_n = 1'b1;
    logic       key_b_n = 1'b1;
    logic       key_cal_n = 1'b1;
    logic [3:0] sum;
    logic       cout;
    logic [3:0] op_a, op_b, disp0, disp1;
    logic       disp_blank;
    logic [1:0] state;

    int    checks = 0;
    int    failures = 0;
    snap_t exp_q[$];
    logic  mon_en = 1'b0;

    always #5 clk = ~clk;

    // external four_adder model, ci tied 0
    assign {cout, sum} = {1'b0, op_a} + {1'b0, op_b};

    adder_entry_ctrl #(.DEB_CYCLES(20'd4), .BLINK_CYCLES(25'd8)) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .key_a_n(key_a_n), .key_b_n(key_b_n), .key_cal_n(key_cal_n),
        .sum(sum), .cout(cout),
        .op_a(op_a), .op_b(op_b), .disp0(disp0), .disp1(disp1),
        .disp_blank(disp_blank), .state(state)
    );

    function automatic snap_t mk(input logic [1:0] st, input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] d0, input logic [3:0] d1);
        snap_t s;
        s.st = st; s.a = a; s.b = b; s.d0 = d0; s.d1 = d1;
        return s;
    endfunction

    task automatic compare_snap();
        snap_t act;
        snap_t exp;
        act = mk(state, op_a, op_b, disp0, disp1);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change: got state=%0d op_a=%0d op_b=%0d disp0=%0d disp1=%0d, required no change",
                     act.st, act.a, act.b, act.d0, act.d1);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp
`ifndef CARRY_BLINK_EN
                || disp_blank !== 1'b0
`endif
               ) begin
                failures++;
                $display("FAIL snapshot: got state=%0d op_a=%0d op_b=%0d disp0=%0d disp1=%0d blank=%0b, required state=%0d op_a=%0d op_b=%0d disp0=%0d disp1=%0d",
                         act.st, act.a, act.b, act.d0, act.d1, disp_blank,
                         exp.st, exp.a, exp.b, exp.d0, exp.d1);
            end
        end
    endtask

    // Monitor: first compare on enable, then one compare per observed change
    initial begin
        logic [9:0] prev;
        wait (mon_en);
        @(negedge clk);
        compare_snap();
        prev = {state, op_a, op_b};
        forever begin
            @(negedge clk);
            if ({state, op_a, op_b} !== prev) begin
                @(negedge clk);
                compare_snap();
                prev = {state, op_a, op_b};
            end
        end
    end

    task automatic press(input int which, input logic [3:0] v, input int low_cycles);
        sw = v;
        @(negedge clk);
        if (which == 0) key_a_n = 1'b0;
        else if (which == 1) key_b_n = 1'b0;
        else key_cal_n = 1'b0;
        repeat (low_cycles) @(negedge clk);
        key_a_n = 1'b1; key_b_n = 1'b1; key_cal_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int toggles;
        logic last;
        // 1 reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(mk(2'd0, 4'd0, 4'd0, 4'd0, 4'd0));
        mon_en = 1'b1;
        repeat (10) @(negedge clk);

        // 2 entry 3 + 5
        exp_q.push_back(mk(2'd1, 4'd3, 4'd0, 4'd3, 4'd0)); press(0, 4'd3, 8);
        exp_q.push_back(mk(2'd2, 4'd3, 4'd5, 4'd3, 4'd5)); press(1, 4'd5, 8);
        sw = 4'd15;
        repeat (10) @(negedge clk);
        exp_q.push_back(mk(2'd3, 4'd3, 4'd5, 4'd8, 4'd0)); press(2, 4'd15, 8);
        exp_q.push_back(mk(2'd0, 4'd0, 4'd0, 4'd0, 4'd0)); press(2, 4'd15, 8);

        // 3 carry 9 + 8
        exp_q.push_back(mk(2'd1, 4'd9, 4'd0, 4'd9, 4'd0)); press(0, 4'd9, 8);
        exp_q.push_back(mk(2'd2, 4'd9, 4'd8, 4'd9, 4'd8)); press(1, 4'd8, 8);
        exp_q.push_back(mk(2'd3, 4'd9, 4'd8, 4'd1, 4'd1)); press(2, 4'd0, 8);
`ifdef CARRY_BLINK_EN
        toggles = 0;
        last = disp_blank;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (disp_blank !== last) toggles++;
            last = disp_blank;
        end
        checks++;
        if (toggles < 4 || toggles > 5) begin
            failures++;
            $display("FAIL blink_toggles: got %0d, required 4..5", toggles);
        end
`else
        toggles = 0;
        last = 1'b0;
`endif
        exp_q.push_back(mk(2'd0, 4'd0, 4'd0, 4'd0, 4'd0)); press(2, 4'd0, 8);
        checks++;
        if (disp_blank !== 1'b0) begin
            failures++;
            $display("FAIL blank_after_clear: got %0b, required 0", disp_blank);
        end

        // 4 bounce: 3-cycle glitch rejected, 6-cycle press accepted once
        press(0, 4'd7, 3);
        exp_q.push_back(mk(2'd1, 4'd7, 4'd0, 4'd7, 4'd0)); press(0, 4'd7, 6);
        exp_q.push_back(mk(2'd2, 4'd7, 4'd2, 4'd7, 4'd2)); press(1, 4'd2, 8);

        // 5 priority: A and CAL together in READY
        sw = 4'd4;
        @(negedge clk);
        key_a_n = 1'b0; key_cal_n = 1'b0;
        exp_q.push_back(mk(2'd3, 4'd7, 4'd2, 4'd9, 4'd0));
        repeat (8) @(negedge clk);
        key_a_n = 1'b1; key_cal_n = 1'b1;
        repeat (12) @(negedge clk);

        // 6 clear, then reset in READY, then key held through reset
        exp_q.push_back(mk(2'd0, 4'd0, 4'd0, 4'd0, 4'd0)); press(2, 4'd0, 8);
        exp_q.push_back(mk(2'd1, 4'd1, 4'd0, 4'd1, 4'd0)); press(0, 4'd1, 8);
        exp_q.push_back(mk(2'd2, 4'd1, 4'd6, 4'd1, 4'd6)); press(1, 4'd6, 8);
        exp_q.push_back(mk(2'd0, 4'd0, 4'd0, 4'd0, 4'd0));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        sw = 4'd5;
        key_a_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        key_a_n = 1'b1;
        repeat (12) @(negedge clk);
        exp_q.push_back(mk(2'd1, 4'd5, 4'd0, 4'd5, 4'd0)); press(0, 4'd5, 8);

        // drain scoreboard with a bounded wait
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
